// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 139;
  localparam int DATA_BITS            = 8;
  localparam int STOP_BITS            = 1;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous inputs; reset value is selectable per use.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with start-bit validation, break handling,
// and a one-entry valid/ready output buffer that flags overruns and framing errors.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 shift_en;
  logic                 byte_done;
  logic                 stop_bad;

  sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // The start counter is loaded on the detect cycle, so it reads 1 (not 0) at the half-bit point.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    idx_d     = idx_q;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = HALF;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_ONE) begin
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = BIT_LAST;
            idx_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_en = 1'b1;
          cnt_d    = BIT_LAST;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
  end

  // A completion in the same cycle as a handshake replaces the consumed byte without an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= byte_done && valid && !ready;
      if (byte_done) begin
        if (!valid || ready) begin
          data  <= shift_q;
          valid <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes; a monitor pops on each new byte.
module tb_uart_rx;

  localparam int C = 139;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         vcyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         last_new_cyc = 0;
  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a byte is new when valid rises or stays high right after a handshake.
  always @(negedge clk) begin
    if (reset_n) begin
      if (valid && (!prev_valid || prev_hs)) begin
        last_new_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected: got byte %0h expected none", data);
        end else begin
          check("rx_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (valid)     vcyc++;
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      prev_valid = valid;
      prev_hs    = valid && ready;
    end else begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    rx = 1'b0;
    step(C);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(C);
    end
    rx = stop_lvl;
    step(C);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int t0, v0, fe0, ov0;

  initial begin
    rx      = 1'b1;
    ready   = 1'b1;
    reset_n = 1'b0;
    step(3);
    @(negedge clk);
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step(5);

    // 0xA5 with ready high: valid for one cycle at start-edge cycle 1321
    v0 = vcyc; fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    t0 = cyc;
    send_byte(8'hA5, 1'b1);
    step(10);
    check("a5_latency", last_new_cyc - t0, 32'd1323);
    check("a5_valid_cycles", vcyc - v0, 32'd1);
    check("a5_frame_err", fe_cnt - fe0, 32'd0);
    check("a5_overrun", ov_cnt - ov0, 32'd0);

    // 20-cycle glitch is rejected, then 0x3C
    v0 = vcyc; fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    step(20);
    rx = 1'b1;
    step(200);
    check("glitch_valid", vcyc - v0, 32'd0);
    check("glitch_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    step(10);
    check("3c_valid_cycles", vcyc - v0, 32'd1);

    // 0x55 with low stop bit, then a long break
    v0 = vcyc; fe0 = fe_cnt;
    send_byte(8'h55, 1'b0);
    step(3000);
    rx = 1'b1;
    step(20);
    check("break_frame_err", fe_cnt - fe0, 32'd1);
    check("break_valid", vcyc - v0, 32'd0);

    // 0x11 then 0x22 back-to-back with ready low
    ready = 1'b0;
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    step(5);
    @(negedge clk);
    check("ovr_valid", {31'h0, valid}, 32'h1);
    check("ovr_data", {24'h0, data}, 32'h11);
    check("ovr_count", ov_cnt - ov0, 32'd1);
    @(posedge clk); #1;
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    @(negedge clk);
    check("ovr_drain_valid", {31'h0, valid}, 32'h0);
    @(posedge clk); #1;

    // ready exactly on the completion cycle of 0x22 while 0x11 is pending
    ov0 = ov_cnt;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1);
    exp_q.push_back(8'h22);
    fork
      send_byte(8'h22, 1'b1);
      begin
        step(1322);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
      end
    join
    step(5);
    @(negedge clk);
    check("swap_valid", {31'h0, valid}, 32'h1);
    check("swap_data", {24'h0, data}, 32'h22);
    check("swap_overrun", ov_cnt - ov0, 32'd0);
    @(posedge clk); #1;

    // reset during data bit 4, with 0x22 still pending
    fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send_byte(8'hF3, 1'b1);
      begin
        step(720);
        reset_n = 1'b0;
        step(2);
        @(negedge clk);
        check("midrst_data", {24'h0, data}, 32'h0);
        check("midrst_valid", {31'h0, valid}, 32'h0);
        check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
        check("midrst_overrun", {31'h0, overrun}, 32'h0);
        step(15);
        reset_n = 1'b1;
      end
    join
    step(10);
    ready = 1'b1;
    exp_q.push_back(8'hF0);
    send_byte(8'hF0, 1'b1);
    step(10);
    check("f0_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the TinyFPGA system: takes the asynchronous serial line from the board's rx pin and delivers received bytes to the rest of `top`. It synchronises the line, validates the start bit, samples 8N1 frames at mid-bit, and holds each byte in a one-entry output buffer with a valid/ready handshake. Framing errors and overruns are flagged, not hidden.

## Interface
- `CLKS_PER_BIT`, default 139: clock cycles per bit. 16 MHz / 115200 baud ≈ 139. Must be ≥ 4.
- `clk`  in  1  system clock (16 MHz).
- `reset_n`  in  1  asynchronous, active-low reset. One clock, no other clock domains.
- `rx`  in  1  raw serial line, asynchronous to `clk`, idle high.
- `data`  out  8  received byte; stable while `valid` is high.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` on any cycle where `valid && ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a byte completed while the buffer was full; that new byte is dropped.

## Operation
- `rx` passes through a 2-flop synchroniser (flops reset to 1), giving `rx_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: a cycle with `rx_s == 0` enters START. The bit counter is loaded with `H = CLKS_PER_BIT/2` (floor).
- START: at the H point, `rx_s` is re-sampled.
  - If 1: false start, return to IDLE, no flags.
  - If 0: enter DATA with bit index 0.
- DATA: 8 bits, each sampled every `CLKS_PER_BIT` cycles, LSB first, shifted into the shift register. After bit 7, enter STOP.
- STOP: `rx_s` is sampled at the stop point.
  - If 1: byte complete, return to IDLE.
  - If 0: pulse `frame_err`, discard the byte, enter BREAK.
- BREAK: wait for `rx_s == 1`, then IDLE. A held-low line (break) gives exactly one `frame_err`.
- Output buffer:
  - Byte complete and `!valid`: load `data`, set `valid`.
  - Byte complete, `valid` and `!ready`: pulse `overrun`, keep the old `data`.
  - Byte complete, `valid` and `ready` in the same cycle: old byte consumed, new byte loaded, `valid` stays 1, no overrun.
  - `valid && ready` with no completion: clear `valid`.
- Reset values:
  - `data` = 0, `valid` = 0, `frame_err` = 0, `overrun` = 0.
  - FSM = IDLE, counters = 0, synchroniser flops = 1.
- Reset mid-frame: the partial byte is lost and no flags are raised. After release, the receiver resynchronises on the next falling edge seen in IDLE. If released mid-frame, a later data-bit low can be mistaken for a start bit; the frame error that follows is expected behaviour.

## Timing
- Cycle 0 is the first cycle in IDLE with `rx_s == 0`. `rx_s` lags the `rx` pin by 2 cycles.
- Sample points:
  - start bit at cycle H;
  - data bit i at cycle H + (i+1)·CLKS_PER_BIT;
  - stop bit at cycle H + 9·CLKS_PER_BIT.
- `valid`, `frame_err` and `overrun` assert at stop sample + 1. With the default parameter: H = 69, stop sample at cycle 1320, flags at 1321.
- The FSM is back in IDLE on the cycle after the stop sample, so the next start edge can be detected from there. This tolerates back-to-back frames and a sender up to about 5% fast.
- `ready` is combinationally ignored for `valid` within the same cycle. Handshake completes on the clock edge.
- Counter width is `$clog2(CLKS_PER_BIT)` bits; the bit index is 3 bits. The counter counts down and never wraps past 0 in any state.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (5 states);
  - `DEFAULT_CLKS_PER_BIT = 139`;
  - frame constants: `DATA_BITS = 8`, `STOP_BITS = 1`.
- Sub-module `sync2`: generic 2-flop synchroniser with an async active-low reset value parameter. It is reused later for switch inputs.
- `uart_rx` owns the FSM, baud counter, shift register and output buffer.
- It instantiates in `top` directly on the board's rx net. The wrapper's single rx flop becomes redundant but harmless.

## Test plan
- Byte 0xA5 sent at CLKS_PER_BIT = 139, `ready` tied high: `valid` for exactly 1 cycle at cycle 1321 after the start edge, `data = 8'hA5`, no flags.
- 20-cycle low glitch on idle `rx`: no `valid`, no flags; a following 0x3C frame is received correctly.
- Frame 0x55 with the stop bit driven low, then the line held low for 3000 cycles: one `frame_err` pulse, no `valid`; FSM in IDLE after `rx` returns high.
- Bytes 0x11 then 0x22 back-to-back with `ready = 0`: `valid = 1`, `data = 8'h11`, one `overrun` pulse at the second completion. Asserting `ready` then clears `valid`.
- `ready` asserted exactly on the completion cycle of 0x22 while 0x11 is pending: next cycle `data = 8'h22`, `valid = 1`, no `overrun`.
- `reset_n` pulsed low during data bit 4 of a frame: all outputs 0 during reset; a subsequent clean 0xF0 frame is received.
